// File: rtl/dma_channel_sched_pkg.sv
// Shared types and constants for the multi-channel DMA front end.
package dma_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAck,
        StRetire,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        StatusOk        = 3'd0,
        StatusLoadDeny  = 3'd1,
        StatusStoreDeny = 3'd2,
        StatusTimeout   = 3'd3,
        StatusBadDesc   = 3'd4
    } status_e;

    localparam int unsigned ADDR_WIDTH  = 64;
    localparam int unsigned VALID_LOAD  = 1;
    localparam int unsigned VALID_STORE = 2;
    localparam int unsigned VALID_DONE  = 3;
    localparam logic [31:0] DMA_TRUE    = 32'h1;

    // A load denial masks whatever the store side reported.
    function automatic status_e status_from_valid(input logic load_ok, input logic store_ok);
        if (!load_ok) begin
            return StatusLoadDeny;
        end else if (!store_ok) begin
            return StatusStoreDeny;
        end
        return StatusOk;
    endfunction

endpackage

// File: rtl/dma_channel_sched_if.sv
// Channel request/response and dma engine signals of the channel scheduler.
interface dma_channel_sched_if #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_CH-1:0]                        req_i;
    logic [NUM_CH*DATA_WIDTH-1:0]             ch_length_i;
    logic [NUM_CH*dma_sched_pkg::ADDR_WIDTH-1:0] ch_src_addr_i;
    logic [NUM_CH*dma_sched_pkg::ADDR_WIDTH-1:0] ch_dst_addr_i;
    logic [NUM_CH-1:0]                        gnt_o;
    logic [NUM_CH-1:0]                        rsp_valid_o;
    logic [2:0]                               rsp_status_o;
    logic [DATA_WIDTH-1:0]                    dma_start_o;
    logic [DATA_WIDTH-1:0]                    dma_length_o;
    logic [31:0]                              dma_src_lsb_o;
    logic [31:0]                              dma_src_msb_o;
    logic [31:0]                              dma_dst_lsb_o;
    logic [31:0]                              dma_dst_msb_o;
    logic [DATA_WIDTH-1:0]                    dma_valid_i;
    logic [DATA_WIDTH-1:0]                    dma_done_o;

    modport master (
        output req_i, ch_length_i, ch_src_addr_i, ch_dst_addr_i, dma_valid_i,
        input  gnt_o, rsp_valid_o, rsp_status_o, dma_start_o, dma_length_o,
        input  dma_src_lsb_o, dma_src_msb_o, dma_dst_lsb_o, dma_dst_msb_o, dma_done_o
    );

    modport slave (
        input  req_i, ch_length_i, ch_src_addr_i, ch_dst_addr_i, dma_valid_i,
        output gnt_o, rsp_valid_o, rsp_status_o, dma_start_o, dma_length_o,
        output dma_src_lsb_o, dma_src_msb_o, dma_dst_lsb_o, dma_dst_msb_o, dma_done_o
    );
endinterface

// File: rtl/dma_channel_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IdxW'((32'(ptr_i) + off) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_channel_sched.sv
// Round-robin channel front end for a single dma engine: grant, validate, start/done
// sequencing and outcome classification. Every output is a register fed from next-state.
module dma_channel_sched
    import dma_sched_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dma_channel_sched_if.slave bus,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned ScW  = $clog2(START_CYCLES + 1);

    state_e                  state_q, state_d;
    status_e                 status_q, status_d, rsp_status_q;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic [ScW-1:0]          scnt_q, scnt_d;
    logic [NUM_CH-1:0]       owner_q, owner_d, gnt_d, gnt_q, rsp_valid_q;
    logic [DATA_WIDTH-1:0]   len_q, len_d, dma_len_q;
    logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d, dma_src_q, dma_dst_q;
    logic                    bad_q, bad_d;
    logic                    busy_q, err_q, start_q, done_q, drive, rsp_fire;

    logic [NUM_CH-1:0]       arb_gnt;
    logic [PtrW-1:0]         arb_idx;
    logic                    arb_valid;
    logic [DATA_WIDTH-1:0]   cand_len;
    logic [ADDR_WIDTH-1:0]   cand_src, cand_dst;
    logic                    unused_valid;

    rr_arbiter #(
        .N    (NUM_CH),
        .IdxW (PtrW)
    ) u_arb (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign cand_len     = bus.ch_length_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    assign cand_src     = bus.ch_src_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign cand_dst     = bus.ch_dst_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign unused_valid = ^{bus.dma_valid_i[DATA_WIDTH-1:VALID_DONE+1], bus.dma_valid_i[0]};

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        ptr_d    = ptr_q;
        tmo_d    = tmo_q;
        scnt_d   = scnt_q;
        owner_d  = owner_q;
        len_d    = len_q;
        src_d    = src_q;
        dst_d    = dst_q;
        bad_d    = bad_q;
        gnt_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d    = arb_gnt;
                    owner_d  = arb_gnt;
                    len_d    = cand_len;
                    src_d    = cand_src;
                    dst_d    = cand_dst;
                    bad_d    = (cand_len == '1) || (cand_src[2:0] != 3'b0)
                               || (cand_dst[2:0] != 3'b0);
                    status_d = bad_d ? StatusBadDesc : StatusOk;
                    ptr_d    = (arb_idx == PtrW'(NUM_CH - 1)) ? '0 : arb_idx + PtrW'(1);
                    scnt_d   = '0;
                    tmo_d    = '0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (bad_q) begin
                    state_d = StRetire;
                end else if (scnt_q == ScW'(START_CYCLES - 1)) begin
                    state_d = StWait;
                end else begin
                    scnt_d = scnt_q + ScW'(1);
                end
            end
            StWait: begin
                if (bus.dma_valid_i[VALID_DONE]) begin
                    status_d = status_from_valid(bus.dma_valid_i[VALID_LOAD],
                                                 bus.dma_valid_i[VALID_STORE]);
                    state_d  = StAck;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (tmo_d == TmoW'(TIMEOUT_CYCLES)) begin
                        status_d = StatusTimeout;
                        state_d  = StHalt;
                    end
                end
            end
            StAck: begin
                if (!bus.dma_valid_i[VALID_DONE]) begin
                    state_d = StRetire;
                end
            end
            StRetire: state_d = StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // The timeout response fires once, on the WAIT->HALT transition.
    always_comb begin
        drive    = state_d inside {StIssue, StWait, StAck, StRetire};
        rsp_fire = (state_d == StRetire) || ((state_d == StHalt) && (state_q == StWait));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            status_q     <= StatusOk;
            ptr_q        <= '0;
            tmo_q        <= '0;
            scnt_q       <= '0;
            owner_q      <= '0;
            len_q        <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            bad_q        <= 1'b0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_status_q <= StatusOk;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            dma_len_q    <= '0;
            dma_src_q    <= '0;
            dma_dst_q    <= '0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            ptr_q        <= ptr_d;
            tmo_q        <= tmo_d;
            scnt_q       <= scnt_d;
            owner_q      <= owner_d;
            len_q        <= len_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            bad_q        <= bad_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_fire ? owner_d : '0;
            rsp_status_q <= rsp_fire ? status_d : StatusOk;
            busy_q       <= (state_d != StIdle);
            err_q        <= (state_d == StHalt);
            start_q      <= (state_d == StIssue) && !bad_d;
            done_q       <= (state_d == StAck);
            dma_len_q    <= drive ? len_d : '0;
            dma_src_q    <= drive ? src_d : '0;
            dma_dst_q    <= drive ? dst_d : '0;
        end
    end

    assign bus.gnt_o         = gnt_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_status_o  = rsp_status_q;
    assign bus.dma_start_o   = start_q ? DMA_TRUE : '0;
    assign bus.dma_done_o    = done_q ? DMA_TRUE : '0;
    assign bus.dma_length_o  = dma_len_q;
    assign bus.dma_src_lsb_o = dma_src_q[31:0];
    assign bus.dma_src_msb_o = dma_src_q[63:32];
    assign bus.dma_dst_lsb_o = dma_dst_q[31:0];
    assign bus.dma_dst_msb_o = dma_dst_q[63:32];
    assign busy_o            = busy_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_dma_channel_sched.sv
// Self-checking bench for dma_channel_sched with a behavioural dma engine model.
module tb_dma_channel_sched;

    localparam int TB_START = 2;
    localparam int TB_TMO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err;

    dma_channel_sched_if #(.NUM_CH(4), .DATA_WIDTH(32)) bus ();

    dma_channel_sched #(
        .NUM_CH         (4),
        .DATA_WIDTH     (32),
        .START_CYCLES   (TB_START),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_ptr = 0;

    logic [31:0] d_len [4];
    logic [63:0] d_src [4];
    logic [63:0] d_dst [4];

    // Knobs for the dma model
    bit la_k = 1'b1, sa_k = 1'b1, hang_k = 1'b0;
    int lat_k = 0, hold_k = 0;

    // Running totals, sampled with pre-edge values
    int start_total = 0, done_total = 0, gnt_total = 0, rsp_total = 0, done_early = 0;
    logic mon_prev_done = 1'b0, mon_prev_v3 = 1'b0;

    always @(posedge clk) begin
        if (bus.dma_start_o == 32'h1) start_total <= start_total + 1;
        if (bus.dma_done_o == 32'h1) done_total <= done_total + 1;
        if (bus.gnt_o != '0) gnt_total <= gnt_total + 1;
        if (bus.rsp_valid_o != '0) rsp_total <= rsp_total + 1;
        if (mon_prev_done && bus.dma_done_o != 32'h1 && mon_prev_v3) done_early <= done_early + 1;
        mon_prev_done <= (bus.dma_done_o == 32'h1);
        mon_prev_v3   <= bus.dma_valid_i[3];
    end

    // Behavioural dma engine: after start falls, report PMP outcome, hold until done seen.
    initial begin
        bus.dma_valid_i = '0;
        forever begin
            @(negedge clk);
            if (bus.dma_start_o == 32'h1) begin
                while (bus.dma_start_o != '0) @(negedge clk);
                if (!hang_k && !rst) begin
                    repeat (lat_k) @(negedge clk);
                    bus.dma_valid_i = {28'd0, 1'b1, sa_k, la_k, 1'b0};
                    while (bus.dma_done_o != 32'h1 && !rst) @(negedge clk);
                    repeat (hold_k) @(negedge clk);
                    bus.dma_valid_i = '0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    function automatic bit ref_bad(input logic [31:0] len, input logic [63:0] src,
                                   input logic [63:0] dst);
        return (len == 32'hFFFF_FFFF) || (src % 8 != 0) || (dst % 8 != 0);
    endfunction

    function automatic logic [2:0] ref_status(input bit bad, input bit la, input bit sa,
                                              input bit hang);
        if (bad) return 3'd4;
        if (hang) return 3'd3;
        if (!la) return 3'd1;
        if (!sa) return 3'd2;
        return 3'd0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 64'(bus.gnt_o), 0);
        check({tag, "_rsp"}, 64'(bus.rsp_valid_o), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_err"}, 64'(err), 0);
        check({tag, "_start"}, 64'(bus.dma_start_o), 0);
        check({tag, "_done"}, 64'(bus.dma_done_o), 0);
        check({tag, "_len"}, 64'(bus.dma_length_o), 0);
        check({tag, "_src"}, {bus.dma_src_msb_o, bus.dma_src_lsb_o}, 0);
    endtask

    task automatic do_txn(input logic [3:0] mask, input bit la, input bit sa, input int lat,
                          input int hold, input bit hang);
        int k, n, s0, d0, e0, exp_n;
        logic [3:0] exp_g;
        logic [2:0] st;
        bit bad, seen;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.ch_length_i[i*32 +: 32]   = d_len[i];
            bus.ch_src_addr_i[i*64 +: 64] = d_src[i];
            bus.ch_dst_addr_i[i*64 +: 64] = d_dst[i];
        end
        la_k = la; sa_k = sa; lat_k = lat; hold_k = hold; hang_k = hang;
        bus.req_i = mask;
        k     = rr_pick(mask, exp_ptr);
        exp_g = 4'b0001 << k;
        bad   = ref_bad(d_len[k], d_src[k], d_dst[k]);
        st    = ref_status(bad, la, sa, hang);
        s0 = start_total; d0 = done_total; e0 = done_early;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt_o != '0) begin
                seen = 1'b1;
                break;
            end
        end
        bus.req_i = '0;
        check("gnt_seen", 64'(seen), 1);
        if (!seen) return;
        check("gnt_onehot", 64'(bus.gnt_o), 64'(exp_g));
        if (!bad) begin
            check("dma_len", 64'(bus.dma_length_o), 64'(d_len[k]));
            check("dma_src", {bus.dma_src_msb_o, bus.dma_src_lsb_o}, d_src[k]);
            check("dma_dst", {bus.dma_dst_msb_o, bus.dma_dst_lsb_o}, d_dst[k]);
        end
        @(negedge clk);
        check("gnt_pulse", 64'(bus.gnt_o), 0);
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid_o != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 64'(seen), 1);
        if (!seen) return;
        if (bad) exp_n = 1;
        else if (hang) exp_n = TB_START + TB_TMO;
        else exp_n = TB_START + (lat + 1) + (hold + 1);
        check("rsp_onehot", 64'(bus.rsp_valid_o), 64'(exp_g));
        check("rsp_status", 64'(bus.rsp_status_o), 64'(st));
        check("rsp_latency", 64'(n), 64'(exp_n));
        check("start_cycles", 64'(start_total - s0), bad ? 64'd0 : 64'(TB_START));
        check("done_cycles", 64'(done_total - d0), (bad || hang) ? 64'd0 : 64'(hold + 1));
        check("done_held", 64'(done_early - e0), 0);
        exp_ptr = (k + 1) % 4;
        if (bad || !hang) begin
            @(negedge clk);
            check("rsp_pulse", 64'(bus.rsp_valid_o), 0);
            check("idle_busy", 64'(busy), 0);
        end
    endtask

    initial begin
        int r0, g0;
        logic [3:0] m;
        bus.req_i = '0;
        bus.ch_length_i = '0;
        bus.ch_src_addr_i = '0;
        bus.ch_dst_addr_i = '0;
        for (int i = 0; i < 4; i++) begin
            d_len[i] = 32'd7;
            d_src[i] = 64'h1000 + 64'(i) * 64'h100;
            d_dst[i] = 64'h8000 + 64'(i) * 64'h100;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single request on channel 2
        d_len[2] = 32'd3; d_src[2] = 64'h1000; d_dst[2] = 64'h2000;
        do_txn(4'b0100, 1'b1, 1'b1, 0, 0, 1'b0);

        // PMP denials, with longer done hold
        do_txn(4'b0001, 1'b0, 1'b1, 1, 2, 1'b0);
        do_txn(4'b0010, 1'b1, 1'b0, 2, 3, 1'b0);
        do_txn(4'b0001, 1'b0, 1'b0, 0, 1, 1'b0);

        // Bad descriptors
        d_len[1] = 32'hFFFF_FFFF;
        do_txn(4'b0010, 1'b1, 1'b1, 0, 0, 1'b0);
        d_len[1] = 32'd5; d_src[0] = 64'h1004;
        do_txn(4'b0001, 1'b1, 1'b1, 0, 0, 1'b0);
        d_src[0] = 64'h1000; d_dst[3] = 64'h2002;
        do_txn(4'b1000, 1'b1, 1'b1, 0, 0, 1'b0);
        d_dst[3] = 64'h2000;

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 4; i++) begin
                d_len[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 255);
                d_src[i] = {$urandom, $urandom} & ~64'h7;
                d_dst[i] = {$urandom, $urandom} & ~64'h7;
                if ($urandom_range(0, 5) == 0) d_src[i] = d_src[i] | 64'($urandom_range(1, 7));
                if ($urandom_range(0, 5) == 0) d_dst[i] = d_dst[i] | 64'($urandom_range(1, 7));
            end
            m = 4'($urandom_range(1, 15));
            do_txn(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        // Reset while waiting on the dma aborts silently
        for (int i = 0; i < 4; i++) begin
            d_len[i] = 32'd9;
            d_src[i] = 64'h4000 + 64'(i) * 64'h40;
            d_dst[i] = 64'h9000 + 64'(i) * 64'h40;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.ch_length_i[i*32 +: 32]   = d_len[i];
            bus.ch_src_addr_i[i*64 +: 64] = d_src[i];
            bus.ch_dst_addr_i[i*64 +: 64] = d_dst[i];
        end
        hang_k = 1'b1;
        bus.req_i = 4'b0100;
        g0 = gnt_total;
        repeat (3) @(negedge clk);
        bus.req_i = '0;
        check("rstwait_gnt", 64'(gnt_total - g0), 1);
        repeat (5) @(negedge clk);
        check("rstwait_busy", 64'(busy), 1);
        r0 = rsp_total;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstwait");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstwait_no_rsp", 64'(rsp_total - r0), 0);
        exp_ptr = 0;

        // After reset the pointer restarts at 0
        do_txn(4'b1000, 1'b1, 1'b1, 0, 0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            do_txn(4'b1111, 1'b1, 1'b1, t % 3, (t + 1) % 3, 1'b0);
        end

        // Engine never completes: timeout then halt
        do_txn(4'b0001, 1'b1, 1'b1, 0, 0, 1'b1);
        check("halt_err", 64'(err), 1);
        check("halt_busy", 64'(busy), 1);
        check("halt_start", 64'(bus.dma_start_o), 0);
        check("halt_len", 64'(bus.dma_length_o), 0);
        @(negedge clk);
        bus.req_i = 4'b1111;
        g0 = gnt_total;
        repeat (10) @(negedge clk);
        bus.req_i = '0;
        check("halt_no_gnt", 64'(gnt_total - g0), 0);
        check("halt_err_sticky", 64'(err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
